// File: rtl/alu_core_pipe.sv
// Two-stage valid/ready ALU: S1 holds the accepted operands, S2 holds the computed
// result and CTL byte. A carry register chains ADDC/SUBB across consecutive ops.
module alu_core_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [6:0]       in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_c,
  output logic [7:0]       out_ctl
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_BAD  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_ADDC = 3'd6;
  localparam logic [2:0] OP_SUBB = 3'd7;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [6:0]       err;
  } req_t;

  req_t             s1_q, s1_d, req;
  logic             s1_vld_q, s1_vld_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH:0]   s2_c_q, s2_c_d;
  logic [7:0]       s2_ctl_q, s2_ctl_d;
  logic             cy_q, cy_d;

  logic             s1_adv, accept, xfer, is_arith;
  logic [WIDTH:0]   a_x, b_x, cin, res_c;
  logic [7:0]       res_ctl;
  logic             ovf;

  assign req = '{a: in_a, b: in_b, op: in_op, err: in_err};

  // Handshake: S1 drains whenever S2 is empty or being consumed this cycle.
  always_comb begin
    s1_adv   = !s2_vld_q || out_ready;
    in_ready = !rst && (!s1_vld_q || s1_adv);
    accept   = in_valid && in_ready;
    xfer     = s1_vld_q && s1_adv;
  end

  // Result and flags, evaluated on the S1 contents for the S1->S2 transfer.
  always_comb begin
    a_x      = {1'b0, s1_q.a};
    b_x      = {1'b0, s1_q.b};
    cin      = {{WIDTH{1'b0}}, cy_q};
    is_arith = s1_q.op[2];
    res_c    = '0;
    res_ctl  = 8'h00;
    ovf      = 1'b0;
    if (s1_q.err != 7'd0) begin
      res_ctl = {s1_q.err, 1'b0};
    end else if (s1_q.op == OP_BAD) begin
      res_ctl = 8'h92;
    end else begin
      case (s1_q.op)
        OP_AND:  res_c = a_x & b_x;
        OP_OR:   res_c = a_x | b_x;
        OP_XOR:  res_c = a_x ^ b_x;
        OP_ADD:  res_c = a_x + b_x;
        OP_SUB:  res_c = a_x - b_x;
        OP_ADDC: res_c = a_x + b_x + cin;
        OP_SUBB: res_c = a_x - b_x - cin;
        default: res_c = '0;
      endcase
      // Signed overflow: ADD family needs equal signs, SUB family differing signs.
      if (is_arith)
        ovf = ((s1_q.a[WIDTH-1] ^ s1_q.b[WIDTH-1]) == s1_q.op[0]) &&
              (res_c[WIDTH-1] != s1_q.a[WIDTH-1]);
      res_ctl[6] = is_arith & res_c[WIDTH];
      res_ctl[5] = ovf;
      res_ctl[4] = (res_c[WIDTH-1:0] == '0);
      res_ctl[3] = res_c[WIDTH-1];
    end
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    s2_vld_d = s2_vld_q;
    s2_c_d   = s2_c_q;
    s2_ctl_d = s2_ctl_q;
    cy_d     = cy_q;
    if (xfer) s1_vld_d = 1'b0;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_d     = req;
    end
    if (xfer) begin
      s2_vld_d = 1'b1;
      s2_c_d   = res_c;
      s2_ctl_d = res_ctl;
      if (is_arith && s1_q.err == 7'd0) cy_d = res_c[WIDTH];
    end else if (out_ready) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      s2_c_q   <= '0;
      s2_ctl_q <= 8'h00;
      cy_q     <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      s2_vld_q <= s2_vld_d;
      s2_c_q   <= s2_c_d;
      s2_ctl_q <= s2_ctl_d;
      cy_q     <= cy_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_c     = s2_c_q;
  assign out_ctl   = s2_ctl_q;

endmodule

// File: tb/tb_alu_core_pipe.sv
// Scoreboard bench for alu_core_pipe: one WIDTH=32 and one WIDTH=8 instance,
// directed vectors pushed at accept, a negedge monitor pops and compares.
module tb_alu_core_pipe;

  logic clk, rst;
  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32;
  logic [2:0]  op32;
  logic [6:0]  err32;
  logic [32:0] oc32;
  logic [7:0]  octl32;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [6:0]  err8;
  logic [8:0]  oc8;
  logic [7:0]  octl8;

  typedef struct {
    logic [32:0] c;
    logic [7:0]  ctl;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  bit   lat_on = 1'b1;

  alu_core_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .in_op(op32), .in_err(err32), .out_valid(ov32), .out_ready(or32),
    .out_c(oc32), .out_ctl(octl32));

  alu_core_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_op(op8), .in_err(err8), .out_valid(ov8), .out_ready(or8),
    .out_c(oc8), .out_ctl(octl8));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one op, wait (bounded) for acceptance, push its expected response.
  task automatic send(input bit w8, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [6:0] err,
                      input logic [32:0] ec, input logic [7:0] ectl);
    bit rdy;
    int n;
    exp_t e;
    if (w8) begin
      iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; err8 = err;
    end else begin
      iv32 = 1'b1; a32 = a; b32 = b; op32 = op; err32 = err;
    end
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = w8 ? ir8 : ir32;
      n++;
    end
    if (!rdy) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      e.c = ec; e.ctl = ectl; e.cyc = cyc; e.lat = lat_on;
      if (w8) q8.push_back(e); else q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w8) iv8 = 1'b0; else iv32 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov32 && or32) begin
      if (q32.size() == 0) chk("unexpected_out32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("out_c32", 64'(oc32), 64'(e.c));
        chk("out_ctl32", 64'(octl32), 64'(e.ctl));
        if (e.lat) chk("latency32", 64'(cyc - e.cyc), 64'd2);
      end
    end
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) chk("unexpected_out8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk("out_c8", 64'(oc8), 64'(e.c));
        chk("out_ctl8", 64'(octl8), 64'(e.ctl));
        if (e.lat) chk("latency8", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    iv32 = 0; a32 = 0; b32 = 0; op32 = 0; err32 = 0; or32 = 1'b1;
    iv8 = 0;  a8 = 0;  b8 = 0;  op8 = 0;  err8 = 0;  or8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    chk("rst_out_c32", 64'(oc32), 64'd0);
    chk("rst_out_ctl32", 64'(octl32), 64'd0);
    chk("rst_in_ready32", 64'(ir32), 64'd0);
    chk("rst_in_ready8", 64'(ir8), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Arithmetic, carry chaining, invalid/error frames, logic ops.
    send(0, 3'd4, 32'hFFFFFFFF, 32'h00000001, 7'd0, 33'h1_0000_0000, 8'h50);
    send(0, 3'd6, 32'h0, 32'h0, 7'd0, 33'h0_0000_0001, 8'h00);
    send(0, 3'd4, 32'h7FFFFFFF, 32'h00000001, 7'd0, 33'h0_8000_0000, 8'h28);
    send(0, 3'd5, 32'h0, 32'h1, 7'd0, 33'h1_FFFF_FFFF, 8'h48);
    send(0, 3'd7, 32'h5, 32'h2, 7'd0, 33'h0_0000_0002, 8'h00);
    send(0, 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'd0, 33'h1_FFFF_FFFE, 8'h48);
    send(0, 3'd3, 32'h12345678, 32'h1, 7'd0, 33'h0, 8'h92);
    send(0, 3'd4, 32'h1, 32'h1, 7'b0100100, 33'h0, 8'h48);
    send(0, 3'd6, 32'h0, 32'h0, 7'd0, 33'h0_0000_0001, 8'h00);
    send(0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 7'd0, 33'h0_F000_F000, 8'h08);
    send(0, 3'd1, 32'h0, 32'h0, 7'd0, 33'h0, 8'h10);
    send(0, 3'd2, 32'hAAAAAAAA, 32'h55555555, 7'd0, 33'h0_FFFF_FFFF, 8'h08);

    // Backpressure: two ops fill the pipe, a third is refused while stalled.
    repeat (3) @(posedge clk);
    #1;
    lat_on = 1'b0;
    or32 = 1'b0;
    send(0, 3'd4, 32'h1, 32'h2, 7'd0, 33'h3, 8'h00);
    send(0, 3'd2, 32'hF, 32'hF, 7'd0, 33'h0, 8'h10);
    iv32 = 1'b1; a32 = 32'h3; b32 = 32'h1; op32 = 3'd5; err32 = 7'd0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(ir32), 64'd0);
      chk("stall_out_valid", 64'(ov32), 64'd1);
      chk("stall_out_c", 64'(oc32), 64'h3);
    end
    @(posedge clk);
    #1 or32 = 1'b1;
    fork
      begin
        send(0, 3'd5, 32'h3, 32'h1, 7'd0, 33'h2, 8'h00);
        send(0, 3'd6, 32'h10, 32'h20, 7'd0, 33'h30, 8'h00);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("stream_valid", 64'(ov32), 64'd1);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with two ops in flight (cy set to 1 by the SUB) discards everything.
    or32 = 1'b0;
    send(0, 3'd5, 32'h0, 32'h1, 7'd0, 33'h1_FFFF_FFFF, 8'h48);
    send(0, 3'd4, 32'h0, 32'h0, 7'd0, 33'h0, 8'h10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(ir32), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("post_rst_out_valid", 64'(ov32), 64'd0);
    chk("post_rst_out_c", 64'(oc32), 64'd0);
    chk("post_rst_out_ctl", 64'(octl32), 64'd0);
    chk("post_rst_in_ready", 64'(ir32), 64'd1);
    @(posedge clk);
    #1;
    or32 = 1'b1;
    lat_on = 1'b1;
    send(0, 3'd6, 32'h0, 32'h0, 7'd0, 33'h0, 8'h10);

    // Narrow instance.
    send(1, 3'd4, 32'hFF, 32'h01, 7'd0, 33'h100, 8'h50);
    send(1, 3'd6, 32'h0, 32'h0, 7'd0, 33'h001, 8'h00);
    send(1, 3'd4, 32'h7F, 32'h01, 7'd0, 33'h080, 8'h28);
    send(1, 3'd5, 32'h0, 32'h1, 7'd0, 33'h1FF, 8'h48);
    send(1, 3'd3, 32'h5, 32'h5, 7'd0, 33'h000, 8'h92);

    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
